// File: rtl/diff_decode.sv
// Rebuilds operand B from base operand A by XOR-flipping one bit per accepted index.
// Optional macro DIFF_DECODE_COUNT_EN adds the flips output (handshakes in the last sequence).
module diff_decode #(
    parameter int MAX_FLIPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base,
    input  logic        eq_in,
    input  logic        idx_valid,
    input  logic [4:0]  idx,
    input  logic        idx_last,
    output logic        idx_ready,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
`ifdef DIFF_DECODE_COUNT_EN
    output logic [5:0]  flips,
`endif
    output logic        err
);

    localparam int CW = $clog2(MAX_FLIPS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [31:0]     r_acc;
    logic [31:0]     r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_done;
    logic            r_err;
    logic            r_idx_ready;
    logic            r_busy;
`ifdef DIFF_DECODE_COUNT_EN
    logic [5:0]      r_flips;
`endif

    logic            w_hs;
    logic [31:0]     w_acc_flip;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_at_max;

    // 5-to-32 one-hot decode of a bit position
    function automatic logic [31:0] onehot32(input logic [4:0] pos);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < 32; k++) begin
            if (pos == 5'(k)) begin
                v[k] = 1'b1;
            end else begin
                v[k] = 1'b0;
            end
        end
        return v;
    endfunction

    // Handshake qualifies only on the registered ready, so idx_valid never feeds back into ready
    always_comb begin
        w_hs       = idx_valid && r_idx_ready;
        w_acc_flip = r_acc ^ onehot32(idx);
        w_cnt_inc  = r_cnt + CW'(1);
        w_at_max   = (r_cnt == CW'(MAX_FLIPS - 1));
    end

    // Sequence FSM; result/done/err are loaded on the edge that enters DONE so they show during DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= 32'd0;
            r_result    <= 32'd0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_idx_ready <= 1'b0;
            r_busy      <= 1'b0;
`ifdef DIFF_DECODE_COUNT_EN
            r_flips     <= 6'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc  <= base;
                        r_cnt  <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (eq_in) begin
                            r_state     <= S_DONE;
                            r_result    <= base;
                            r_done      <= 1'b1;
                            r_idx_ready <= 1'b0;
`ifdef DIFF_DECODE_COUNT_EN
                            r_flips     <= 6'd0;
`endif
                        end else begin
                            r_state     <= S_ACCUM;
                            r_idx_ready <= 1'b1;
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_idx_ready <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_hs) begin
                        r_acc <= w_acc_flip;
                        r_cnt <= w_cnt_inc;
                        // Hitting the cap without idx_last is the error stop
                        if (idx_last || w_at_max) begin
                            r_state     <= S_DONE;
                            r_result    <= w_acc_flip;
                            r_done      <= 1'b1;
                            r_err       <= !idx_last;
                            r_idx_ready <= 1'b0;
`ifdef DIFF_DECODE_COUNT_EN
                            r_flips     <= 6'(w_cnt_inc);
`endif
                        end else begin
                            r_state     <= S_ACCUM;
                            r_idx_ready <= 1'b1;
                        end
                    end else begin
                        r_state     <= S_ACCUM;
                        r_idx_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_idx_ready <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_idx_ready <= 1'b0;
                end
            endcase
        end
    end

    assign idx_ready = r_idx_ready;
    assign result    = r_result;
    assign done      = r_done;
    assign busy      = r_busy;
    assign err       = r_err;
`ifdef DIFF_DECODE_COUNT_EN
    assign flips     = r_flips;
`endif

endmodule
